jump_redirect_ctrl: RTL and testbench

- Sequences control-flow redirection for the 5-stage pipeline.
- Classifies the decode-stage opcode as j, jal or jr, then:
  - holds decode while a jr source operand is not ready;
  - issues a one-cycle PC redirect;
  - squashes wrong-path fetches for a fixed number of cycles;
  - arbitrates the jal link write ($r31 = PC+1) onto the regfile write port, with writeback taking priority.
- Sits between decode, the PC register, the IF/ID flush logic and the regfile write mux.

---
 rtl/jump_redirect_ctrl_pkg.sv | 23 ++
 rtl/jump_class_decode.sv | 15 +
 rtl/jump_redirect_ctrl.sv | 159 +++++++++++++++
 tb/tb_jump_redirect_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jump_redirect_ctrl_pkg.sv
// Shared constants for jump classification and redirect sequencing.
// Used by jump_redirect_ctrl, jump_class_decode and the hazard unit.
package jump_redirect_ctrl_pkg;

    localparam int unsigned OPCODE_W         = 5;
    localparam int unsigned TARGET_W         = 27;
    localparam int unsigned REG_IDX_W        = 5;
    localparam int unsigned FLUSH_CNT_W      = 3;
    localparam int unsigned STAT_W           = 16;
    localparam int unsigned LINK_REG_DEFAULT = 31;

    localparam logic [OPCODE_W-1:0] OP_J   = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_JAL = 5'b00011;
    localparam logic [OPCODE_W-1:0] OP_JR  = 5'b00100;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_RS  = 2'd1,
        S_REDIRECT = 2'd2,
        S_FLUSH    = 2'd3
    } state_t;

endpackage

// File: rtl/jump_class_decode.sv
// Combinational opcode classifier producing one-hot jump-type flags.
module jump_class_decode
    import jump_redirect_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output logic                is_j,
    output logic                is_jal,
    output logic                is_jr
);

    assign is_j   = (opcode == OP_J);
    assign is_jal = (opcode == OP_JAL);
    assign is_jr  = (opcode == OP_JR);

endmodule

// File: rtl/jump_redirect_ctrl.sv
// Jump redirect controller: PC redirect, wrong-path flush and jal link write.
// Optional JUMP_REDIRECT_STATS_EN adds saturating jump/stall counters.
module jump_redirect_ctrl
    import jump_redirect_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned LINK_REG     = LINK_REG_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic [OPCODE_W-1:0]  dec_opcode,
    input  logic [ADDR_W-1:0]    dec_pc,
    input  logic [TARGET_W-1:0]  dec_target,
    input  logic [ADDR_W-1:0]    rs_data,
    input  logic                 rs_ready,
    input  logic                 wb_busy,
    output logic                 stall,
    output logic                 redirect_valid,
    output logic [ADDR_W-1:0]    redirect_pc,
    output logic                 flush,
    output logic                 link_we,
    output logic [REG_IDX_W-1:0] link_addr,
    output logic [ADDR_W-1:0]    link_data,
    output logic [STAT_W-1:0]    stat_jumps,
    output logic [STAT_W-1:0]    stat_stalls
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    state_t                 state;
    logic [FLUSH_CNT_W-1:0] flush_cnt;
    logic                   link_pend;
    logic [ADDR_W-1:0]      target;
    logic                   is_j;
    logic                   is_jal;
    logic                   is_jr;
    logic                   accept_c;
    logic [ADDR_W-1:0]      jump_tgt_c;

    jump_class_decode u_class (
        .opcode (dec_opcode),
        .is_j   (is_j),
        .is_jal (is_jal),
        .is_jr  (is_jr)
    );

    // A second jal must wait until the previous link has reached the regfile.
    assign dec_ready  = (state == S_IDLE) && !(is_jal && link_pend);
    assign accept_c   = dec_valid && dec_ready;
    assign jump_tgt_c = {dec_pc[ADDR_W-1:TARGET_W], dec_target};
    assign stall      = (state == S_WAIT_RS) ||
                        ((state == S_IDLE) && dec_valid && is_jr && !rs_ready);
    assign link_we    = link_pend && !wb_busy;
    assign link_addr  = REG_IDX_W'(LINK_REG);
    assign redirect_pc = target;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            flush_cnt      <= '0;
            link_pend      <= 1'b0;
            target         <= '0;
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            link_data      <= '0;
        end else begin
            redirect_valid <= 1'b0;
            if (link_we) begin
                link_pend <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        if (is_j || is_jal) begin
                            target         <= jump_tgt_c;
                            state          <= S_REDIRECT;
                            redirect_valid <= 1'b1;
                            flush          <= 1'b1;
                        end
                        if (is_jal) begin
                            link_pend <= 1'b1;
                            link_data <= dec_pc + ADDR_W'(1);
                        end
                        if (is_jr) begin
                            if (rs_ready) begin
                                target         <= rs_data;
                                state          <= S_REDIRECT;
                                redirect_valid <= 1'b1;
                                flush          <= 1'b1;
                            end else begin
                                state <= S_WAIT_RS;
                            end
                        end
                    end
                end
                S_WAIT_RS: begin
                    if (rs_ready) begin
                        target         <= rs_data;
                        state          <= S_REDIRECT;
                        redirect_valid <= 1'b1;
                        flush          <= 1'b1;
                    end
                end
                S_REDIRECT: begin
                    if (FLUSH_CYCLES == 1) begin
                        state <= S_IDLE;
                        flush <= 1'b0;
                    end else begin
                        state     <= S_FLUSH;
                        flush_cnt <= FLUSH_LAST;
                    end
                end
                S_FLUSH: begin
                    // The cycle holding a count of 1 is the last flushed cycle.
                    if (flush_cnt == FLUSH_CNT_W'(1)) begin
                        state     <= S_IDLE;
                        flush     <= 1'b0;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - FLUSH_CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef JUMP_REDIRECT_STATS_EN
    logic [STAT_W-1:0] jump_count;
    logic [STAT_W-1:0] stall_count;

    // Saturating event counters for performance monitoring.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            jump_count  <= '0;
            stall_count <= '0;
        end else begin
            if ((state == S_REDIRECT) && (jump_count != '1)) begin
                jump_count <= jump_count + STAT_W'(1);
            end
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + STAT_W'(1);
            end
        end
    end

    assign stat_jumps  = jump_count;
    assign stat_stalls = stall_count;
`else
    assign stat_jumps  = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Self-checking bench for jump_redirect_ctrl: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_jump_redirect_ctrl;

    localparam int unsigned FLUSH_N = 2;
    localparam logic [4:0]  OPJ     = 5'b00001;
    localparam logic [4:0]  OPJAL   = 5'b00011;
    localparam logic [4:0]  OPJR    = 5'b00100;

    logic        clock;
    logic        reset_n;
    logic        dec_valid;
    logic        dec_ready;
    logic [4:0]  dec_opcode;
    logic [31:0] dec_pc;
    logic [26:0] dec_target;
    logic [31:0] rs_data;
    logic        rs_ready;
    logic        wb_busy;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        link_we;
    logic [4:0]  link_addr;
    logic [31:0] link_data;
    logic [15:0] stat_jumps;
    logic [15:0] stat_stalls;
    logic [4:0]  ctl;

    int tests_run;
    int tests_failed;

    jump_redirect_ctrl #(
        .ADDR_W       (32),
        .FLUSH_CYCLES (FLUSH_N),
        .LINK_REG     (31)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_opcode     (dec_opcode),
        .dec_pc         (dec_pc),
        .dec_target     (dec_target),
        .rs_data        (rs_data),
        .rs_ready       (rs_ready),
        .wb_busy        (wb_busy),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .link_we        (link_we),
        .link_addr      (link_addr),
        .link_data      (link_data),
        .stat_jumps     (stat_jumps),
        .stat_stalls    (stat_stalls)
    );

    // Control bits in the order ready, stall, redirect_valid, flush, link_we.
    assign ctl = {dec_ready, stall, redirect_valid, flush, link_we};

    always #5 clock = ~clock;

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] pc,
                         input logic [26:0] t, input logic [31:0] rsd, input logic rsr,
                         input logic wb);
        dec_valid  = v;
        dec_opcode = op;
        dec_pc     = pc;
        dec_target = t;
        rs_data    = rsd;
        rs_ready   = rsr;
        wb_busy    = wb;
    endtask

    task automatic drive_idle(input logic wb);
        drive(1'b0, 5'd0, 32'd0, 27'd0, 32'd0, 1'b1, wb);
    endtask

    task automatic test_reset();
        drive_idle(1'b0);
        reset_n = 1'b0;
        nxt();
        nxt();
        @(negedge clock);
        tests_run++;
        if (ctl !== 5'b10000) begin
            tests_failed++;
            $display("FAIL reset_ctl got=%b exp=10000", ctl);
        end
        tests_run++;
        if ({redirect_pc, link_data} !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_data got pc=%h ld=%h exp=0", redirect_pc, link_data);
        end
        tests_run++;
        if (link_addr !== 5'd31) begin
            tests_failed++;
            $display("FAIL reset_link_addr got=%0d exp=31", link_addr);
        end
        reset_n = 1'b1;
        nxt();
    endtask

    task automatic test_jump();
        logic [4:0] ec [4];
        ec = '{5'b10000, 5'b00110, 5'b00010, 5'b10000};
        for (int c = 0; c < 4; c++) begin
            if (c == 0) drive(1'b1, OPJ, 32'h0800_0010, 27'h100, 32'd0, 1'b1, 1'b0);
            else        drive_idle(1'b0);
            @(negedge clock);
            tests_run++;
            if (ctl !== ec[c]) begin
                tests_failed++;
                $display("FAIL jump_ctl[%0d] got=%b exp=%b", c, ctl, ec[c]);
            end
            if (c == 1) begin
                tests_run++;
                if (redirect_pc !== 32'h0800_0100) begin
                    tests_failed++;
                    $display("FAIL jump_pc got=%h exp=08000100", redirect_pc);
                end
            end
            nxt();
        end
    endtask

    task automatic test_jal_link();
        logic [4:0] ec [6];
        logic       wb [6];
        ec = '{5'b10000, 5'b00110, 5'b00010, 5'b10000, 5'b10001, 5'b10000};
        wb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 6; c++) begin
            if (c == 0) drive(1'b1, OPJAL, 32'h40, 27'h200, 32'd0, 1'b1, wb[c]);
            else        drive_idle(wb[c]);
            @(negedge clock);
            tests_run++;
            if (ctl !== ec[c]) begin
                tests_failed++;
                $display("FAIL jal_ctl[%0d] got=%b exp=%b", c, ctl, ec[c]);
            end
            if (c == 1) begin
                tests_run++;
                if (redirect_pc !== 32'h200) begin
                    tests_failed++;
                    $display("FAIL jal_pc got=%h exp=00000200", redirect_pc);
                end
            end
            if (c == 4) begin
                tests_run++;
                if ({link_addr, link_data} !== {5'd31, 32'h41}) begin
                    tests_failed++;
                    $display("FAIL jal_link got addr=%0d data=%h exp addr=31 data=00000041",
                             link_addr, link_data);
                end
            end
            nxt();
        end
    endtask

    task automatic test_jr_wait();
        logic [4:0] ec [6];
        logic       rr [6];
        ec = '{5'b11000, 5'b01000, 5'b01000, 5'b00110, 5'b00010, 5'b10000};
        rr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int c = 0; c < 6; c++) begin
            drive(c == 0, (c == 0) ? OPJR : 5'd0, 32'h80, 27'd0, 32'h1234, rr[c], 1'b0);
            @(negedge clock);
            tests_run++;
            if (ctl !== ec[c]) begin
                tests_failed++;
                $display("FAIL jr_ctl[%0d] got=%b exp=%b", c, ctl, ec[c]);
            end
            if (c == 3) begin
                tests_run++;
                if (redirect_pc !== 32'h1234) begin
                    tests_failed++;
                    $display("FAIL jr_pc got=%h exp=00001234", redirect_pc);
                end
            end
            nxt();
        end
    endtask

    task automatic test_link_block();
        logic        tv  [13];
        logic [4:0]  top [13];
        logic [31:0] tpc [13];
        logic [26:0] tt  [13];
        logic        tw  [13];
        logic [4:0]  ec  [13];
        tv  = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0};
        top = '{OPJAL, 5'd0, 5'd0, OPJAL, OPJ, 5'd0, 5'd0, OPJAL, OPJAL, OPJAL, 5'd0, 5'd0, 5'd0};
        tpc = '{32'h100, 0, 0, 32'h200, 32'h300, 0, 0, 32'h200, 32'h200, 32'h200, 0, 0, 0};
        tt  = '{27'h10, 0, 0, 27'h20, 27'h50, 0, 0, 27'h20, 27'h20, 27'h20, 0, 0, 0};
        tw  = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        ec  = '{5'b10000, 5'b00110, 5'b00010, 5'b00000, 5'b10000, 5'b00110, 5'b00010,
                5'b00000, 5'b00001, 5'b10000, 5'b00111, 5'b00010, 5'b10000};
        for (int c = 0; c < 13; c++) begin
            drive(tv[c], top[c], tpc[c], tt[c], 32'd0, 1'b1, tw[c]);
            @(negedge clock);
            tests_run++;
            if (ctl !== ec[c]) begin
                tests_failed++;
                $display("FAIL block_ctl[%0d] got=%b exp=%b", c, ctl, ec[c]);
            end
            if (c == 5 || c == 10) begin
                tests_run++;
                if (redirect_pc !== ((c == 5) ? 32'h50 : 32'h20)) begin
                    tests_failed++;
                    $display("FAIL block_pc[%0d] got=%h", c, redirect_pc);
                end
            end
            if (c == 8 || c == 10) begin
                tests_run++;
                if (link_data !== ((c == 8) ? 32'h101 : 32'h201)) begin
                    tests_failed++;
                    $display("FAIL block_link_data[%0d] got=%h", c, link_data);
                end
            end
            nxt();
        end
    endtask

    task automatic test_nonjump();
        logic [4:0] ops [3];
        ops = '{5'b00000, 5'b00000, 5'b10110};
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, ops[c], 32'h1000 + 32'(c), 27'h7, 32'd0, 1'b0, 1'b0);
            @(negedge clock);
            tests_run++;
            if (ctl !== 5'b10000) begin
                tests_failed++;
                $display("FAIL nonjump_ctl[%0d] got=%b exp=10000", c, ctl);
            end
            nxt();
        end
    endtask

    task automatic test_reset_in_flush();
        logic [4:0] ec [6];
        ec = '{5'b10000, 5'b00110, 5'b00010, 5'b10000, 5'b10000, 5'b10000};
        for (int c = 0; c < 6; c++) begin
            if (c == 0) drive(1'b1, OPJAL, 32'h500, 27'h60, 32'd0, 1'b1, 1'b1);
            else        drive_idle(c < 3);
            reset_n = (c != 2);
            @(negedge clock);
            tests_run++;
            if (ctl !== ec[c]) begin
                tests_failed++;
                $display("FAIL rstflush_ctl[%0d] got=%b exp=%b", c, ctl, ec[c]);
            end
            if (c == 3) begin
                tests_run++;
                if ({redirect_pc, link_data} !== 64'd0) begin
                    tests_failed++;
                    $display("FAIL rstflush_data got pc=%h ld=%h exp=0", redirect_pc, link_data);
                end
            end
            nxt();
        end
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        bit          m_wait, m_redir, m_pend;
        int          m_fl;
        logic [31:0] m_tgt, m_ld;
        bit          idle, e_rdy, e_stall, e_lwe;
        logic [4:0]  e_ctl, op;
        int          pick;
        drive_idle(1'b0);
        reset_n = 1'b0;
        nxt();
        reset_n = 1'b1;
        m_wait = 0; m_redir = 0; m_pend = 0; m_fl = 0; m_tgt = '0; m_ld = '0;
        for (int n = 0; n < 800; n++) begin
            pick = int'($urandom_range(0, 5));
            case (pick)
                0:       op = OPJ;
                1, 5:    op = OPJAL;
                2:       op = OPJR;
                3:       op = 5'd0;
                default: op = 5'($urandom());
            endcase
            drive($urandom_range(0, 3) != 0, op, $urandom(), 27'($urandom()), $urandom(),
                  $urandom_range(0, 4) > 1, $urandom_range(0, 1) == 1);
            reset_n = ($urandom_range(0, 49) != 0);
            idle    = !m_wait && (m_fl == 0);
            e_rdy   = idle && !((dec_opcode == OPJAL) && m_pend);
            e_stall = m_wait || (idle && dec_valid && (dec_opcode == OPJR) && !rs_ready);
            e_lwe   = m_pend && !wb_busy;
            e_ctl   = {e_rdy, e_stall, m_redir, m_fl > 0, e_lwe};
            @(negedge clock);
            tests_run++;
            if (ctl !== e_ctl) begin
                tests_failed++;
                $display("FAIL rand_ctl[%0d] got=%b exp=%b", n, ctl, e_ctl);
            end
            if (m_redir) begin
                tests_run++;
                if (redirect_pc !== m_tgt) begin
                    tests_failed++;
                    $display("FAIL rand_pc[%0d] got=%h exp=%h", n, redirect_pc, m_tgt);
                end
            end
            if (e_lwe) begin
                tests_run++;
                if (link_data !== m_ld) begin
                    tests_failed++;
                    $display("FAIL rand_link[%0d] got=%h exp=%h", n, link_data, m_ld);
                end
            end
            if (!reset_n) begin
                m_wait = 0; m_redir = 0; m_pend = 0; m_fl = 0; m_tgt = '0; m_ld = '0;
            end else begin
                if (e_lwe) m_pend = 0;
                m_redir = 0;
                if (m_fl > 0) m_fl--;
                if (m_wait) begin
                    if (rs_ready) begin
                        m_wait = 0; m_tgt = rs_data; m_redir = 1; m_fl = FLUSH_N;
                    end
                end else if (idle && dec_valid && e_rdy) begin
                    if (dec_opcode == OPJ || dec_opcode == OPJAL) begin
                        m_tgt = {dec_pc[31:27], dec_target}; m_redir = 1; m_fl = FLUSH_N;
                    end
                    if (dec_opcode == OPJAL) begin
                        m_pend = 1; m_ld = dec_pc + 32'd1;
                    end
                    if (dec_opcode == OPJR) begin
                        if (rs_ready) begin
                            m_tgt = rs_data; m_redir = 1; m_fl = FLUSH_N;
                        end else begin
                            m_wait = 1;
                        end
                    end
                end
            end
            nxt();
        end
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d tests", tests_run);
        $fatal(1);
    end

    initial begin
        clock        = 1'b0;
        reset_n      = 1'b0;
        tests_run    = 0;
        tests_failed = 0;
        drive_idle(1'b0);
        test_reset();
        test_jump();
        test_jal_link();
        test_jr_wait();
        test_link_block();
        test_nonjump();
        test_reset_in_flush();
        test_random();
        $display("[TB] stats jumps=%0d stalls=%0d", stat_jumps, stat_stalls);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
